// File: rtl/submax_pkg.sv
// Shared types, FP32 constants and ordering helpers for the row-max subtraction sequencer.
package submax_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_DRAIN,
        ST_SUB_ISSUE,
        ST_SUB_WAIT,
        ST_Y_WR,
        ST_FIN
    } state_e;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_SIGN_BIT = 32'h8000_0000;

    // Monotonic unsigned key: larger key means larger FP32 value.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ FP32_SIGN_BIT);
    endfunction

    function automatic logic fp32_gt(input logic [31:0] a, input logic [31:0] b);
        return fp32_key(a) > fp32_key(b);
    endfunction

endpackage

// File: rtl/submax_adder_arb.sv
// Owner tracking and operand/handshake muxing for the shared FP32 adder.
module submax_adder_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sweep_sub_i,
    input  logic        int_start_i,
    input  logic [31:0] int_a_i,
    input  logic [31:0] int_b_i,
    output logic        int_free_o,
    input  logic        ext_start_i,
    input  logic [31:0] ext_a_i,
    input  logic [31:0] ext_b_i,
    output logic        ext_ready_o,
    output logic        ext_busy_o,
    output logic        ext_done_o,
    output logic [31:0] ext_z_o,
    output logic        add_start_o,
    output logic [31:0] add_a_o,
    output logic [31:0] add_b_o,
    input  logic        add_busy_i,
    input  logic        add_done_i,
    input  logic [31:0] add_z_i
);

    logic ext_own_q, ext_own_d;
    logic int_own_q, int_own_d;
    logic ext_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_own_q <= 1'b0;
            int_own_q <= 1'b0;
        end else begin
            ext_own_q <= ext_own_d;
            int_own_q <= int_own_d;
        end
    end

    // Ownership is taken on a granted start and released by the adder's done pulse.
    always_comb begin
        ext_own_d = ext_own_q;
        int_own_d = int_own_q;
        if (ext_acc)         ext_own_d = 1'b1;
        else if (add_done_i) ext_own_d = 1'b0;
        if (int_start_i)     int_own_d = 1'b1;
        else if (add_done_i) int_own_d = 1'b0;
    end

    assign ext_ready_o = !add_busy_i && !int_own_q && !sweep_sub_i;
    assign ext_acc     = ext_start_i && ext_ready_o;
    assign int_free_o  = !add_busy_i && !ext_own_q;
    assign ext_busy_o  = add_busy_i && ext_own_q;
    assign ext_done_o  = add_done_i && ext_own_q;
    assign ext_z_o     = add_z_i;
    assign add_start_o = ext_acc || int_start_i;
    assign add_a_o     = ext_acc ? ext_a_i : int_a_i;
    assign add_b_o     = ext_acc ? ext_b_i : int_b_i;

endmodule

// File: rtl/submax_row_sched.sv
// Row-wise max search over the score SRAM, then Y = X - rowmax through the shared adder.
module submax_row_sched
    import submax_pkg::*;
#(
    parameter int unsigned T   = 4,
    parameter int unsigned T_W = (T <= 1) ? 1 : $clog2(T)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           sc_re,
    output logic [T_W-1:0] sc_tq,
    output logic [T_W-1:0] sc_tk,
    input  logic [31:0]    sc_rdata,
    input  logic           sc_rvalid,
    input  logic           cpu_re,
    input  logic [T_W-1:0] cpu_tq,
    input  logic [T_W-1:0] cpu_tk,
    output logic           cpu_ready,
    output logic [31:0]    cpu_rdata,
    output logic           cpu_rvalid,
    output logic           add_start,
    output logic [31:0]    add_a,
    output logic [31:0]    add_b,
    input  logic           add_busy,
    input  logic           add_done,
    input  logic [31:0]    add_z,
    input  logic           ext_add_start,
    input  logic [31:0]    ext_a,
    input  logic [31:0]    ext_b,
    output logic           ext_add_ready,
    output logic           ext_busy,
    output logic           ext_done,
    output logic [31:0]    ext_z,
    output logic           y_we,
    output logic [T_W-1:0] y_tq,
    output logic [T_W-1:0] y_tk,
    output logic [31:0]    y_wdata
);

    localparam logic [T_W-1:0] LAST = T_W'(T - 1);

    state_e         state_q, state_d;
    logic [T_W-1:0] row_q, row_d, k_q, k_d, cap_q, cap_d;
    logic [31:0]    max_q, max_d, yw_q, yw_d;
    logic [31:0]    rowbuf_q [T];
    logic [31:0]    rowbuf_d [T];
    logic           busy_q, busy_d, done_q, done_d, tag_q;

    logic        cpu_grant, cap_v, is_max, int_start, int_free;
    logic [31:0] elem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            k_q      <= '0;
            cap_q    <= '0;
            max_q    <= '0;
            yw_q     <= '0;
            rowbuf_q <= '{default: '0};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tag_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            k_q      <= k_d;
            cap_q    <= cap_d;
            max_q    <= max_d;
            yw_q     <= yw_d;
            rowbuf_q <= rowbuf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tag_q    <= cpu_grant;
        end
    end

    // Score port: CPU passes through only in IDLE; tag routes the return one cycle later.
    assign cpu_ready  = (state_q == ST_IDLE);
    assign cpu_grant  = cpu_ready && cpu_re;
    assign sc_re      = cpu_grant || (state_q == ST_RD_ISSUE);
    assign sc_tq      = cpu_grant ? cpu_tq : row_q;
    assign sc_tk      = cpu_grant ? cpu_tk : k_q;
    assign cpu_rdata  = sc_rdata;
    assign cpu_rvalid = sc_rvalid && tag_q;
    assign cap_v      = sc_rvalid && !tag_q &&
                        ((state_q == ST_RD_ISSUE) || (state_q == ST_RD_DRAIN));

    assign elem      = rowbuf_q[k_q];
    assign is_max    = (elem == max_q);
    assign int_start = (state_q == ST_SUB_ISSUE) && !is_max && int_free;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        k_d      = k_q;
        cap_d    = cap_q;
        max_d    = max_q;
        yw_d     = yw_q;
        rowbuf_d = rowbuf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (cap_v) begin
            rowbuf_d[cap_q] = sc_rdata;
            if ((cap_q == '0) || fp32_gt(sc_rdata, max_q)) max_d = sc_rdata;
            cap_d = (cap_q == LAST) ? '0 : cap_q + T_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD_ISSUE;
                    row_d   = '0;
                    k_d     = '0;
                    cap_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = ST_RD_DRAIN;
                end else begin
                    k_d = k_q + T_W'(1);
                end
            end
            ST_RD_DRAIN: state_d = ST_SUB_ISSUE;
            ST_SUB_ISSUE: begin
                if (is_max) begin
                    yw_d    = FP32_POS_ZERO;
                    state_d = ST_Y_WR;
                end else if (int_free) begin
                    state_d = ST_SUB_WAIT;
                end
            end
            ST_SUB_WAIT: begin
                if (add_done) begin
                    yw_d    = add_z;
                    state_d = ST_Y_WR;
                end
            end
            ST_Y_WR: begin
                if (k_q != LAST) begin
                    k_d     = k_q + T_W'(1);
                    state_d = ST_SUB_ISSUE;
                end else if (row_q != LAST) begin
                    k_d     = '0;
                    row_d   = row_q + T_W'(1);
                    state_d = ST_RD_ISSUE;
                end else begin
                    k_d     = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign y_we    = (state_q == ST_Y_WR);
    assign y_tq    = row_q;
    assign y_tk    = k_q;
    assign y_wdata = yw_q;

    submax_adder_arb u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .sweep_sub_i ((state_q == ST_SUB_ISSUE) || (state_q == ST_SUB_WAIT)),
        .int_start_i (int_start),
        .int_a_i     (elem),
        .int_b_i     ({~max_q[31], max_q[30:0]}),
        .int_free_o  (int_free),
        .ext_start_i (ext_add_start),
        .ext_a_i     (ext_a),
        .ext_b_i     (ext_b),
        .ext_ready_o (ext_add_ready),
        .ext_busy_o  (ext_busy),
        .ext_done_o  (ext_done),
        .ext_z_o     (ext_z),
        .add_start_o (add_start),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_busy_i  (add_busy),
        .add_done_i  (add_done),
        .add_z_i     (add_z)
    );

endmodule

// File: tb/tb_submax_row_sched.sv
// Randomized sweeps of submax_row_sched against a real-arithmetic reference of Y = X - rowmax.
module tb_submax_row_sched;

    localparam int unsigned T   = 4;
    localparam int unsigned T_W = 2;
    localparam int          L   = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start = 1'b0, busy, done;
    logic           sc_re;
    logic [T_W-1:0] sc_tq, sc_tk;
    logic [31:0]    sc_rdata = '0;
    logic           sc_rvalid = 1'b0;
    logic           cpu_re = 1'b0, cpu_ready, cpu_rvalid;
    logic [T_W-1:0] cpu_tq = '0, cpu_tk = '0;
    logic [31:0]    cpu_rdata;
    logic           add_start, add_busy, add_done;
    logic [31:0]    add_a, add_b, add_z;
    logic           ext_add_start = 1'b0, ext_add_ready, ext_busy, ext_done;
    logic [31:0]    ext_a = '0, ext_b = '0, ext_z;
    logic           y_we;
    logic [T_W-1:0] y_tq, y_tk;
    logic [31:0]    y_wdata;

    logic [31:0] mem  [T][T];
    logic [31:0] ymem [T][T];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    submax_row_sched #(.T(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .sc_re(sc_re), .sc_tq(sc_tq), .sc_tk(sc_tk), .sc_rdata(sc_rdata), .sc_rvalid(sc_rvalid),
        .cpu_re(cpu_re), .cpu_tq(cpu_tq), .cpu_tk(cpu_tk), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_busy(add_busy), .add_done(add_done), .add_z(add_z),
        .ext_add_start(ext_add_start), .ext_a(ext_a), .ext_b(ext_b),
        .ext_add_ready(ext_add_ready), .ext_busy(ext_busy), .ext_done(ext_done), .ext_z(ext_z),
        .y_we(y_we), .y_tq(y_tq), .y_tk(y_tk), .y_wdata(y_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // FP32 <-> real for normal values and zero; test data keeps all sums exact.
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0;
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(124, 130)),
                4'($urandom_range(0, 15)), 19'd0};
    endfunction

    // Score SRAM: one-cycle read latency.
    always @(posedge clk) begin
        sc_rvalid <= sc_re;
        sc_rdata  <= mem[sc_tq][sc_tk];
    end

    // Shared adder: latency L, done on the last busy cycle; not reset with the DUT.
    int          acnt = 0;
    logic [31:0] az   = '0;
    always @(posedge clk) begin
        if (add_start) begin
            acnt <= L;
            az   <= r2f(f2r(add_a) + f2r(add_b));
        end else if (acnt != 0) begin
            acnt <= acnt - 1;
        end
    end
    assign add_busy = (acnt != 0);
    assign add_done = (acnt == 1);
    assign add_z    = az;

    // Per-sweep event counters, restarted when a start is accepted.
    int sw_yw, sw_int, sw_int_r0, sw_busy, sw_done, sw_scre, sw_cpurv, sw_extdone, sw_viol, sw_early;
    int n_yw_all = 0, n_extdone_all = 0;
    logic [31:0] sw_extz;
    bit ext_pend = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ext_pend = 1'b0;
        end else begin
            if (start && cpu_ready) begin
                sw_yw = 0; sw_int = 0; sw_int_r0 = 0; sw_busy = 0; sw_done = 0;
                sw_scre = 0; sw_cpurv = 0; sw_extdone = 0; sw_viol = 0; sw_early = 0;
                sw_extz = '0;
                for (int r = 0; r < T; r++)
                    for (int k = 0; k < T; k++) ymem[r][k] = 32'hDEAD_BEEF;
            end
            if (y_we) begin
                ymem[y_tq][y_tk] = y_wdata;
                sw_yw++;
                n_yw_all++;
            end
            if (add_start && add_busy) sw_viol++;
            if (add_start && ext_add_start && ext_add_ready) begin
                ext_pend = 1'b1;
            end else if (add_start) begin
                sw_int++;
                if (sw_yw < T) sw_int_r0++;
                if (ext_pend) sw_early++;
            end
            if (ext_done) begin
                sw_extdone++;
                sw_extz  = ext_z;
                ext_pend = 1'b0;
                n_extdone_all++;
            end
            if (busy) sw_busy++;
            if (done) sw_done++;
            if (sc_re && busy) sw_scre++;
            if (cpu_rvalid && busy) sw_cpurv++;
        end
    end

    task automatic fill_rand();
        for (int r = 0; r < T; r++)
            for (int k = 0; k < T; k++)
                if (k > 0 && $urandom_range(0, 3) == 0) mem[r][k] = mem[r][$urandom_range(0, k - 1)];
                else mem[r][k] = rnd_fp();
    endtask

    // Reference: row max by real comparison, Y from real subtraction, cycle budget from the timing rules.
    task automatic check_sweep(input int exp_cpurv, input bit ext_job);
        int n_add = 0, n_add_r0 = 0, exp_busy = 0;
        logic [31:0] mx, ey;
        for (int r = 0; r < T; r++) begin
            mx = mem[r][0];
            for (int k = 1; k < T; k++) if (f2r(mem[r][k]) > f2r(mx)) mx = mem[r][k];
            exp_busy += T + 1;
            for (int k = 0; k < T; k++) begin
                if (mem[r][k] == mx) begin
                    ey = 32'h0;
                    exp_busy += 2;
                end else begin
                    ey = r2f(f2r(mem[r][k]) - f2r(mx));
                    exp_busy += L + 2;
                    n_add++;
                    if (r == 0) n_add_r0++;
                end
                chk($sformatf("y[%0d][%0d]", r, k), ymem[r][k], ey);
            end
        end
        chk("int_add_count", 32'(sw_int), 32'(n_add));
        chk("row0_add_count", 32'(sw_int_r0), 32'(n_add_r0));
        chk("done_once", 32'(sw_done), 1);
        chk("y_writes", 32'(sw_yw), T * T);
        chk("sweep_reads", 32'(sw_scre), T * T);
        chk("cpu_rvalid_busy", 32'(sw_cpurv), 32'(exp_cpurv));
        chk("busy_cycles", 32'(sw_busy), 32'(exp_busy));
        chk("add_while_busy", 32'(sw_viol), 0);
        if (ext_job) begin
            chk("ext_done_cnt", 32'(sw_extdone), 1);
            chk("ext_z", sw_extz, 32'h4040_0000);
            chk("int_before_ext", 32'(sw_early), 0);
        end
    endtask

    task automatic run_sweep(input bit ext_job, input bit repulse, input bit cpu_spam, input bit cpu_at_start);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1;
        if (ext_job) begin
            ext_add_start = 1'b1; ext_a = 32'h3F80_0000; ext_b = 32'h4000_0000;
        end
        if (cpu_at_start) begin
            cpu_re = 1'b1; cpu_tq = 2'd3; cpu_tk = 2'd0;
        end
        @(negedge clk);
        if (cpu_at_start) begin
            chk("start_cpu_sc_re", 32'(sc_re), 1);
            chk("start_cpu_tq", 32'(sc_tq), 3);
        end
        if (ext_job) chk("ext_ready_idle", 32'(ext_add_ready), 1);
        @(posedge clk); #1;
        start = 1'b0; ext_add_start = 1'b0;
        cpu_re = cpu_spam; cpu_tq = 2'd1; cpu_tk = 2'd2;
        @(negedge clk);
        chk("busy_rise", 32'(busy), 1);
        if (cpu_at_start) begin
            chk("start_cpu_rvalid", 32'(cpu_rvalid), 1);
            chk("start_cpu_rdata", cpu_rdata, mem[3][0]);
        end
        if (cpu_spam) chk("cpu_ready_busy", 32'(cpu_ready), 0);
        cyc = 0;
        while (sw_done == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            start = repulse && (cyc == 7 || cyc == 30);
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 cpu_re = 1'b0;
        check_sweep(cpu_at_start ? 1 : 0, ext_job);
    endtask

    task automatic reset_mid();
        int cyc = 0, yw0, ed0;
        fill_rand();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(add_start && sw_yw >= T) && cyc < 3000);
        chk("reach_row1_add", 32'(sw_yw >= T), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", 32'({busy, done, sc_re, add_start, y_we, cpu_rvalid, ext_busy, ext_done}), 0);
        chk("midrst_cpu_ready", 32'(cpu_ready), 1);
        chk("midrst_ext_ready", 32'(ext_add_ready), 32'(acnt == 0));
        yw0 = n_yw_all;
        ed0 = n_extdone_all;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_rst_no_ywr", 32'(n_yw_all - yw0), 0);
        chk("post_rst_no_extdone", 32'(n_extdone_all - ed0), 0);
        chk("post_rst_idle", 32'({busy, cpu_ready}), 32'b01);
        run_sweep(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_outs", 32'({busy, done, sc_re, add_start, y_we, cpu_rvalid, ext_busy, ext_done}), 0);
        chk("rst_cpu_ready", 32'(cpu_ready), 1);
        chk("rst_ext_ready", 32'(ext_add_ready), 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed rows: positive ties, then all-negative.
        fill_rand();
        mem[0][0] = 32'h3F80_0000; mem[0][1] = 32'h4040_0000;
        mem[0][2] = 32'h4000_0000; mem[0][3] = 32'h4040_0000;
        mem[1][0] = 32'hBF80_0000; mem[1][1] = 32'hBF00_0000;
        mem[1][2] = 32'hC000_0000; mem[1][3] = 32'hC080_0000;
        run_sweep(1'b0, 1'b0, 1'b0, 1'b0);
        chk("row0_y0", ymem[0][0], 32'hC000_0000);
        chk("row0_y2", ymem[0][2], 32'hBF80_0000);
        chk("row0_adds", 32'(sw_int_r0), 2);
        chk("row1_y", ymem[1][2], 32'hBFC0_0000);
        chk("row1_y3", ymem[1][3], 32'hC060_0000);
        chk("row1_ymax", ymem[1][1], 32'h0);

        // CPU debug read while idle.
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_tq = 2'd2; cpu_tk = 2'd1;
        @(negedge clk);
        chk("cpu_sc_re", 32'(sc_re), 1);
        chk("cpu_sc_addr", 32'({sc_tq, sc_tk}), 32'({2'd2, 2'd1}));
        @(posedge clk); #1 cpu_re = 1'b0;
        @(negedge clk);
        chk("cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("cpu_rdata", cpu_rdata, mem[2][1]);
        @(negedge clk);
        chk("cpu_rvalid_drop", 32'(cpu_rvalid), 0);

        fill_rand();
        run_sweep(1'b1, 1'b1, 1'b1, 1'b0);
        reset_mid();
        fill_rand();
        run_sweep(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            fill_rand();
            run_sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
